// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and default framing.
// Also used by the transmit side of the UART path.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_rx_state_t;

  localparam int UART_OVERSAMPLE = 16;
  localparam int UART_DATA_BITS  = 8;

endpackage

// File: rtl/uart_rx_if.sv
// Received-byte bus from uart_rx to the VU-meter datapath.
// Pulse-only: the consumer captures data while valid is high.
interface uart_rx_if #(
  parameter int data_bits = 8
);

  logic [data_bits-1:0] data;
  logic                 valid;
  logic                 frame_err;
  logic                 busy;

  modport master (
    output data,
    output valid,
    output frame_err,
    output busy
  );

  modport slave (
    input data,
    input valid,
    input frame_err,
    input busy
  );

endinterface

// File: rtl/uart_rx_sync2.sv
// Two-flop synchronizer for asynchronous single-bit inputs.
// Resets to 0 on the asynchronous active-low reset.
module sync2 (
  input  logic clk_board,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk_board or negedge reset) begin
    if (!reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, mid-bit oversampling on ticks of the 16x-baud clock.
// Delivers each byte as a one-cycle valid pulse; frame errors pulse separately.
module uart_rx
  import uart_pkg::*;
#(
  parameter int data_bits  = UART_DATA_BITS,
  parameter int oversample = UART_OVERSAMPLE
) (
  input  logic     clk_board,
  input  logic     reset,
  input  logic     uart_clk,
  input  logic     enable,
  input  logic     rx,
  uart_rx_if.master bus
);

  localparam int TW = $clog2(oversample);
  localparam int BW = $clog2(data_bits);

  localparam logic [TW-1:0] HALF_LAST = TW'(oversample / 2 - 1);
  localparam logic [TW-1:0] FULL_LAST = TW'(oversample - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(data_bits - 1);

  localparam logic [1:0] S_IDLE  = 2'(IDLE);
  localparam logic [1:0] S_START = 2'(START);
  localparam logic [1:0] S_DATA  = 2'(DATA);
  localparam logic [1:0] S_STOP  = 2'(STOP);

  logic rx_s;
  logic uclk_s;
  logic uclk_s_d;
  logic tick;

  logic [1:0]           state;
  logic                 armed;
  logic [TW-1:0]        tick_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [data_bits-1:0] sh;
  logic [data_bits-1:0] data_q;
  logic                 valid_q;
  logic                 ferr_q;

  sync2 u_sync_rx (
    .clk_board (clk_board),
    .reset     (reset),
    .d         (rx),
    .q         (rx_s)
  );

  sync2 u_sync_uclk (
    .clk_board (clk_board),
    .reset     (reset),
    .d         (uart_clk),
    .q         (uclk_s)
  );

  always_ff @(posedge clk_board or negedge reset) begin
    if (!reset) uclk_s_d <= 1'b0;
    else        uclk_s_d <= uclk_s;
  end

  assign tick = uclk_s & ~uclk_s_d;

  always_ff @(posedge clk_board or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      armed    <= 1'b0;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      sh       <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      if (rx_s) armed <= 1'b1;
      if (!enable) begin
        state    <= S_IDLE;
        tick_cnt <= '0;
        bit_cnt  <= '0;
      end else if (tick) begin
        unique case (state)
          S_IDLE: begin
            if (armed && !rx_s) begin
              state    <= S_START;
              tick_cnt <= '0;
            end
          end
          S_START: begin
            if (tick_cnt == HALF_LAST) begin
              tick_cnt <= '0;
              bit_cnt  <= '0;
              state    <= rx_s ? S_IDLE : S_DATA;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          S_DATA: begin
            if (tick_cnt == FULL_LAST) begin
              tick_cnt <= '0;
              sh       <= {rx_s, sh[data_bits-1:1]};
              bit_cnt  <= bit_cnt + 1'b1;
              if (bit_cnt == BIT_LAST) state <= S_STOP;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          S_STOP: begin
            if (tick_cnt == FULL_LAST) begin
              tick_cnt <= '0;
              state    <= S_IDLE;
              if (rx_s) begin
                data_q  <= sh;
                valid_q <= 1'b1;
              end else begin
                ferr_q <= 1'b1;
                armed  <= 1'b0;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.data      = data_q;
  assign bus.valid     = valid_q;
  assign bus.frame_err = ferr_q;
  assign bus.busy      = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: clean, back-to-back, glitch, break,
// abort and reset scenarios with hand-computed bytes.
module tb_uart_rx;

  localparam int BIT = 640;

  logic clk_board;
  logic reset;
  logic uart_clk;
  logic enable;
  logic rx;

  uart_rx_if #(.data_bits(8)) bus ();

  uart_rx dut (
    .clk_board (clk_board),
    .reset     (reset),
    .uart_clk  (uart_clk),
    .enable    (enable),
    .rx        (rx),
    .bus       (bus.master)
  );

  int checks;
  int errors;
  int vcnt;
  int fecnt;
  int both;
  logic [7:0] q[$];

  initial clk_board = 1'b0;
  always #5 clk_board = ~clk_board;

  initial uart_clk = 1'b0;
  always #20 uart_clk = ~uart_clk;

  always @(negedge clk_board) begin
    if (reset) begin
      if (bus.valid) begin
        vcnt = vcnt + 1;
        q.push_back(bus.data);
      end
      if (bus.frame_err) fecnt = fecnt + 1;
      if (bus.valid && bus.frame_err) both = both + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    vcnt  = 0;
    fecnt = 0;
    both  = 0;
    q.delete();
  endtask

  function automatic logic [7:0] qat(input int i);
    logic [7:0] v;
    v = 8'hxx;
    if (q.size() > i) v = q[i];
    return v;
  endfunction

  task automatic send(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    #BIT;
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      #BIT;
    end
    rx = stop;
    #BIT;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clr();
    reset  = 1'b0;
    enable = 1'b1;
    rx     = 1'b1;
    #23;
    chk("reset_data", 32'(bus.data), 32'h00);
    chk("reset_valid", 32'(bus.valid), 32'h0);
    chk("reset_ferr", 32'(bus.frame_err), 32'h0);
    chk("reset_busy", 32'(bus.busy), 32'h0);
    reset = 1'b1;
    #(BIT);

    // clean byte
    clr();
    send(8'hA5, 1'b1);
    #100;
    chk("clean_vcnt", 32'(vcnt), 32'd1);
    chk("clean_data", 32'(qat(0)), 32'hA5);
    chk("clean_ferr", 32'(fecnt), 32'd0);
    chk("clean_busy", 32'(bus.busy), 32'h0);

    // back-to-back
    clr();
    send(8'h00, 1'b1);
    send(8'hFF, 1'b1);
    send(8'h3C, 1'b1);
    #100;
    chk("b2b_vcnt", 32'(vcnt), 32'd3);
    chk("b2b_d0", 32'(qat(0)), 32'h00);
    chk("b2b_d1", 32'(qat(1)), 32'hFF);
    chk("b2b_d2", 32'(qat(2)), 32'h3C);

    // glitch on idle line
    clr();
    #(BIT);
    rx = 1'b0;
    #120;
    chk("glitch_busy_hi", 32'(bus.busy), 32'h1);
    rx = 1'b1;
    #(BIT * 2);
    chk("glitch_vcnt", 32'(vcnt), 32'd0);
    chk("glitch_ferr", 32'(fecnt), 32'd0);
    chk("glitch_busy_lo", 32'(bus.busy), 32'h0);

    // framing error then break
    clr();
    send(8'h55, 1'b0);
    #(BIT * 30);
    chk("break_ferr", 32'(fecnt), 32'd1);
    chk("break_vcnt", 32'(vcnt), 32'd0);
    chk("break_data", 32'(bus.data), 32'h3C);
    chk("break_busy", 32'(bus.busy), 32'h0);
    rx = 1'b1;
    #(BIT * 2);
    send(8'h81, 1'b1);
    #(BIT);
    chk("after_break_vcnt", 32'(vcnt), 32'd1);
    chk("after_break_data", 32'(qat(0)), 32'h81);
    chk("after_break_ferr", 32'(fecnt), 32'd1);

    // abort mid-DATA
    clr();
    rx = 1'b0;
    #(BIT);
    rx = 1'b0;
    #(BIT);
    rx = 1'b1;
    #(BIT / 2);
    chk("abort_busy_pre", 32'(bus.busy), 32'h1);
    @(negedge clk_board);
    enable = 1'b0;
    @(posedge clk_board);
    #1;
    chk("abort_busy_post", 32'(bus.busy), 32'h0);
    @(negedge clk_board);
    enable = 1'b1;
    #(BIT * 3);
    chk("abort_vcnt", 32'(vcnt), 32'd0);
    chk("abort_ferr", 32'(fecnt), 32'd0);
    send(8'h7E, 1'b1);
    #(BIT);
    chk("abort_next_vcnt", 32'(vcnt), 32'd1);
    chk("abort_next_data", 32'(qat(0)), 32'h7E);

    // reset mid-frame
    clr();
    rx = 1'b0;
    #(BIT * 4);
    @(negedge clk_board);
    reset = 1'b0;
    #1;
    chk("mreset_data", 32'(bus.data), 32'h00);
    chk("mreset_valid", 32'(bus.valid), 32'h0);
    chk("mreset_ferr", 32'(bus.frame_err), 32'h0);
    chk("mreset_busy", 32'(bus.busy), 32'h0);
    rx = 1'b1;
    #100;
    reset = 1'b1;
    #(BIT * 2);
    chk("mreset_nopulse", 32'(vcnt + fecnt), 32'd0);
    send(8'hC3, 1'b1);
    #(BIT);
    chk("mreset_vcnt", 32'(vcnt), 32'd1);
    chk("mreset_q", 32'(qat(0)), 32'hC3);
    chk("mreset_bus", 32'(bus.data), 32'hC3);
    chk("never_both", 32'(both), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
